// File: rtl/connect_split_pkg.sv
// connect_split_pkg: packet width, destination-field defaults, a range-check helper and
// the CONNECT_SPLIT_PORT slice macro used to address one port's lane of a flattened bus.
`ifndef CONNECT_SPLIT_PKG_SV
`define CONNECT_SPLIT_PKG_SV

`define CONNECT_SPLIT_PORT(idx, w) ((w)*((idx)+1)-1) -: (w)

package connect_split_pkg;

    localparam int PACKET_WIDTH     = 32;
    localparam int SPLIT_PORTS      = 3;
    localparam int SPLIT_DEST_LSB   = 0;
    localparam int SPLIT_DEST_WIDTH = 2;

    function automatic logic dest_in_range(input int unsigned dest, input int unsigned num);
        return dest < num;
    endfunction

endpackage

`endif

// File: rtl/split_slot.sv
// split_slot: one-entry output register for a single split port; reloads in the same
// cycle it drains so a ready port sustains one packet per cycle.
module split_slot
    import connect_split_pkg::*;
#(
    parameter int DATA_WIDTH = PACKET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  can_load
);

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    assign can_load = !vld_p1 || ready;
    assign valid    = vld_p1;
    assign data     = data_p1;

    // Stage p1: output slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= 1'b1;
        end else if (ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_p1 <= load_data;
        end
    end

endmodule

// File: rtl/connect_split.sv
// connect_split: 1:N packet distributor steering each packet to the port named by its
// destination field. Optional DROP_COUNT output under macro CONNECT_SPLIT_COUNT_EN.
module connect_split
    import connect_split_pkg::*;
#(
    parameter int DATA_WIDTH  = PACKET_WIDTH,
    parameter int CONNECT_NUM = SPLIT_PORTS,
    parameter int DEST_LSB    = SPLIT_DEST_LSB,
    parameter int DEST_WIDTH  = SPLIT_DEST_WIDTH
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              RECEIVE_VALID,
    output logic                              RECEIVE_READY,
    input  logic [DATA_WIDTH-1:0]             RECEIVE_DATA,
    output logic [CONNECT_NUM-1:0]            SEND_VALID,
    input  logic [CONNECT_NUM-1:0]            SEND_READY,
    output logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA,
    output logic                              DEST_ERROR
`ifdef CONNECT_SPLIT_COUNT_EN
    ,
    output logic [15:0]                       DROP_COUNT
`endif
);

    logic [DATA_WIDTH-1:0]  in_data_p0;
    logic                   in_vld_p0;
    logic [DEST_WIDTH-1:0]  dest;
    logic                   dest_ok;
    logic                   drop;
    logic                   dispatch;
    logic                   accept;
    logic [CONNECT_NUM-1:0] slot_free;
    logic [CONNECT_NUM-1:0] slot_load;

    // Destination always comes from the registered packet, never the live input.
    assign dest    = in_data_p0[DEST_LSB +: DEST_WIDTH];
    assign dest_ok = dest_in_range({{(32-DEST_WIDTH){1'b0}}, dest}, CONNECT_NUM);

    always_comb begin
        slot_load = '0;
        for (int i = 0; i < CONNECT_NUM; i++) begin
            slot_load[i] = in_vld_p0 && dest_ok && (dest == DEST_WIDTH'(i)) && slot_free[i];
        end
    end

    assign drop          = in_vld_p0 && !dest_ok;
    assign dispatch      = drop || (|slot_load);
    assign RECEIVE_READY = RST && (!in_vld_p0 || dispatch);
    assign accept        = RECEIVE_VALID && RECEIVE_READY;

    // Stage p0: input register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            in_vld_p0 <= 1'b0;
        end else if (accept) begin
            in_vld_p0 <= 1'b1;
        end else if (dispatch) begin
            in_vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            in_data_p0 <= RECEIVE_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            DEST_ERROR <= 1'b0;
        end else if (drop) begin
            DEST_ERROR <= 1'b1;
        end
    end

`ifdef CONNECT_SPLIT_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST) begin
            DROP_COUNT <= '0;
        end else if (drop) begin
            DROP_COUNT <= sat_inc16(DROP_COUNT);
        end
    end
`endif

    // Stage p1: per-port output slots
    for (genvar i = 0; i < CONNECT_NUM; i++) begin : g_port
        split_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk      (CLK),
            .rst_n    (RST),
            .load     (slot_load[i]),
            .load_data(in_data_p0),
            .ready    (SEND_READY[i]),
            .valid    (SEND_VALID[i]),
            .data     (SEND_DATA[`CONNECT_SPLIT_PORT(i, DATA_WIDTH)]),
            .can_load (slot_free[i])
        );
    end

endmodule

// File: doc/connect_split.md
Name: connect_split

Overview:
1:N packet distributor sitting directly downstream of connect_join. It takes one valid/ready packet stream and steers each packet to one of CONNECT_NUM output ports, chosen by a destination field inside the packet. Each port has its own one-entry output register. The block is fully registered: no combinational path from any SEND_READY to RECEIVE_READY beyond one dispatch term.

Parameters:
DATA_WIDTH, PACKET_WIDTH, packet width in bits.
CONNECT_NUM, 3, number of output ports (>=2).
DEST_LSB, 0, bit position of the destination field LSB in the packet.
DEST_WIDTH, 2, width of the destination field; requires 2**DEST_WIDTH >= CONNECT_NUM.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RST  in  1  synchronous, active-low reset (RST==0 at a rising edge resets).
RECEIVE_VALID  in  1  upstream packet valid.
RECEIVE_READY  out  1  block accepts the packet this cycle.
RECEIVE_DATA  in  DATA_WIDTH  upstream packet.
SEND_VALID  out  CONNECT_NUM  per-port valid.
SEND_READY  in  CONNECT_NUM  per-port ready.
SEND_DATA  out  DATA_WIDTH*CONNECT_NUM  port i occupies bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
DEST_ERROR  out  1  sticky flag: a packet with out-of-range destination was dropped.

Behaviour:
- Reset (RST==0 at an edge): in_full=0, all slot_full=0, SEND_VALID=0, RECEIVE_READY=0 during reset, DEST_ERROR=0. SEND_DATA contents are don't-care but must not be X-propagated into valid.
- Stage 1, input register (in_reg, in_full):
  - RECEIVE_READY = RST && (!in_full || dispatch).
  - An accept (RECEIVE_VALID && RECEIVE_READY) loads in_reg and sets in_full.
- Destination: dest = in_reg[DEST_LSB +: DEST_WIDTH], sampled from in_reg, never from RECEIVE_DATA.
- Dispatch, when in_full and one of:
  - dest < CONNECT_NUM and (!slot_full[dest] || SEND_READY[dest]): load slot[dest], set slot_full[dest].
  - dest >= CONNECT_NUM: drop the packet and set DEST_ERROR; DEST_ERROR clears only on reset.
  - After dispatch, in_full clears unless an accept happens in the same cycle.
- Per port i: SEND_VALID[i] = slot_full[i]. A transfer (SEND_VALID[i] && SEND_READY[i]) clears slot_full[i] unless a dispatch to i happens in the same cycle, in which case the slot reloads and valid stays 1.
- SEND_VALID/SEND_DATA of a port must not change while valid is high and ready is low.
- Latency: a packet accepted at edge k is visible on SEND_* after edge k+1 (2-cycle minimum, accept to port).
- Throughput: 1 packet/cycle sustained, to the same or alternating ports, when the targeted ports are ready.
- Ordering: order is preserved per port and globally at dispatch. Head-of-line blocking is intended: a packet to a stalled port blocks packets to other ports.
- Reset mid-operation discards in_reg and all slots, with no partial output.

Optional Feature:
Macro CONNECT_SPLIT_COUNT_EN.
- Defined: adds output DROP_COUNT [15:0], which increments on each dropped packet, saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent; DEST_ERROR is unchanged either way.

Decomposition:
- Shared package/include: PACKET_WIDTH, destination field position/width constants, and the port slicing macro.
- One natural sub-module: split_slot, a per-port one-entry register with load/valid/ready/data, instantiated CONNECT_NUM times in a generate loop.

Test Plan:
- Reset, then 3 packets with dest=0,1,2 and all SEND_READY=1: each appears only on its own port, 2 cycles after acceptance, DEST_ERROR=0.
- SEND_READY[1]=0, packets dest=1,1,0 back-to-back: first sits in slot1; second holds in_reg with RECEIVE_READY=0; dest=0 is not delivered until SEND_READY[1]=1, then order is 1,1,0.
- dest=3 packet with CONNECT_NUM=3: no SEND_VALID pulses, DEST_ERROR=1 and stays 1; with CONNECT_SPLIT_COUNT_EN defined, DROP_COUNT=1.
- Continuous stream of 100 random packets with dest cycling 0,1,2 and all ready: one accept per cycle, data matches per port in order.
- Assert RST=0 while in_full=1 and slot2 is full: next cycle all SEND_VALID=0 and neither held packet ever appears.
- Loopback with connect_join (echo masters, as in the join bench): random data round-trips, and each packet returns on the port encoded in its dest field.
